// File: rtl/adxl345_frame_packer_if.sv
// Byte-wide valid/ready stream carrying packed accelerometer frames.
//   data  : stream byte (master -> slave)
//   valid : data holds a valid byte (master -> slave)
//   ready : slave accepts the byte on a posedge where valid && ready
`timescale 1ns / 1ps
interface adxl345_frame_packer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/adxl345_frame_packer.sv
// Snapshots the ADXL345 reader's X/Y/Z outputs once per sample period and serialises each
// snapshot as a 9-byte frame: Header, Seq, Xh, Xl, Yh, Yl, Zh, Zl, Chk (XOR of bytes 1..7).
//   clk      : system clock, all logic on posedge
//   reset    : synchronous active-high reset, registered once before use
//   x, y, z  : 2's-complement acceleration samples from the reader
//   stream   : byte stream master (data/valid out, ready in)
//   busy     : a frame is in progress
//   overruns : saturating count of sample ticks dropped while busy
`timescale 1ns / 1ps
module adxl345_frame_packer #(
  parameter int unsigned SamplePeriod = 500000,
  parameter logic [7:0]  Header       = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   x,
  input  logic [15:0]                   y,
  input  logic [15:0]                   z,
  adxl345_frame_packer_if.master        stream,
  output logic                          busy,
  output logic [7:0]                    overruns
);

  localparam int unsigned     CntW   = $clog2(SamplePeriod + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SamplePeriod);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic            reset_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      seq_q, seq_d;
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic [7:0]      ovr_q, ovr_d;

  logic            tick;
  logic            hs;
  logic            last;
  logic [3:0]      next_idx;
  logic [7:0]      chk;
  logic [7:0]      next_byte;

  assign tick     = (cnt_q == CntMax);
  assign hs       = valid_q && stream.ready;
  assign last     = (idx_q == 4'd8);
  assign next_idx = idx_q + 4'd1;
  assign chk      = seq_q ^ x_q[15:8] ^ x_q[7:0] ^ y_q[15:8] ^ y_q[7:0] ^ z_q[15:8] ^ z_q[7:0];

  // Seq is only bumped after the last byte, so seq_q is stable for the whole frame.
  always_comb begin
    next_byte = Header;
    case (next_idx)
      4'd1:    next_byte = seq_q;
      4'd2:    next_byte = x_q[15:8];
      4'd3:    next_byte = x_q[7:0];
      4'd4:    next_byte = y_q[15:8];
      4'd5:    next_byte = y_q[7:0];
      4'd6:    next_byte = z_q[15:8];
      4'd7:    next_byte = z_q[7:0];
      4'd8:    next_byte = chk;
      default: next_byte = Header;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_q) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (tick) state_d = StSend;
      StSend: if (hs && last) state_d = StIdle;
    endcase
  end

  // Datapath and output next-state.
  always_comb begin
    cnt_d   = tick ? CntOne : cnt_q + CntOne;
    idx_d   = idx_q;
    seq_d   = seq_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          // All three axes on the same edge so the frame is one coherent sample.
          x_d     = x;
          y_d     = y;
          z_d     = z;
          idx_d   = 4'd0;
          data_d  = Header;
          valid_d = 1'b1;
        end
      end
      StSend: begin
        if (tick && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
        if (hs) begin
          if (last) begin
            valid_d = 1'b0;
            seq_d   = seq_q + 8'd1;
          end else begin
            idx_d  = next_idx;
            data_d = next_byte;
          end
        end
      end
    endcase
  end

  // Reset is registered once; everything below resets the cycle after it is seen.
  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset_q) begin
      cnt_q   <= CntOne;
      idx_q   <= 4'd0;
      seq_q   <= 8'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      z_q     <= 16'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign stream.data  = data_q;
  assign stream.valid = valid_q;
  assign busy         = (state_q == StSend);
  assign overruns     = ovr_q;

endmodule

// File: tb/tb_adxl345_frame_packer.sv
// Directed bench for adxl345_frame_packer with a byte scoreboard.
`timescale 1ns / 1ps
module tb_adxl345_frame_packer;

  localparam int unsigned Period = 16;

  logic        clk;
  logic        reset;
  logic [15:0] x, y, z;
  logic        busy;
  logic [7:0]  overruns;

  adxl345_frame_packer_if sif ();

  adxl345_frame_packer #(
    .SamplePeriod(Period),
    .Header      (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .z       (z),
    .stream  (sif),
    .busy    (busy),
    .overruns(overruns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq = 8'd0;
  logic       mon_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after posedge; outputs are stable then too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] fx, input logic [15:0] fy, input logic [15:0] fz);
    logic [7:0] b [9];
    b[0] = 8'hA5;
    b[1] = exp_seq;
    b[2] = fx[15:8];
    b[3] = fx[7:0];
    b[4] = fy[15:8];
    b[5] = fy[7:0];
    b[6] = fz[15:8];
    b[7] = fz[7:0];
    b[8] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7];
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
    exp_seq = exp_seq + 8'd1;
    x = fx;
    y = fy;
    z = fz;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (sif.valid === 1'b1) break;
    end
    check(tag, {31'd0, sif.valid}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard plus stall-stability monitor; sampled mid-cycle before the deciding edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid_held", {31'd0, sif.valid}, 32'd1);
        check("stall_data_held", {24'd0, sif.data}, {24'd0, prev_data});
      end
      if (sif.valid === 1'b1 && sif.ready === 1'b1) begin
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("byte", {24'd0, sif.data}, {24'd0, exp_q.pop_front()});
      end
      prev_valid = sif.valid;
      prev_ready = sif.ready;
      prev_data  = sif.data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    logic [3:0] pat;
    reset     = 1'b1;
    sif.ready = 1'b1;
    x = 16'd0;
    y = 16'd0;
    z = 16'd0;
    repeat (3) step();

    // Test 1: first frame timing, content and back-to-back delivery.
    push_frame(16'h1234, 16'hFF00, 16'h0001);
    reset = 1'b0;
    step();
    check("reset_valid", {31'd0, sif.valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overruns", {24'd0, overruns}, 32'd0);
    check("reset_data", {24'd0, sif.data}, 32'd0);
    mon_en = 1'b1;
    repeat (15) step();
    check("pre_tick_valid", {31'd0, sif.valid}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      check("frame_valid_run", {31'd0, sif.valid}, 32'd1);
      check("frame_busy_run", {31'd0, busy}, 32'd1);
    end
    step();
    check("frame_end_valid", {31'd0, sif.valid}, 32'd0);
    check("frame_end_busy", {31'd0, busy}, 32'd0);
    check("frame1_drained", 32'(exp_q.size()), 32'd0);

    // Test 2: sequence numbers increment and wrap 255 -> 0.
    push_frame(16'hABCD, 16'h8000, 16'h7FFF);
    wait_done("frame2_done", 64);
    for (int i = 0; i < 256; i++) begin
      push_frame(16'($urandom), 16'($urandom), 16'($urandom));
      wait_done("seq_frame_done", 64);
    end

    // Test 4: stalled frame drops ticks; then saturation.
    sif.ready = 1'b0;
    push_frame(16'h0102, 16'h0304, 16'h0506);
    wait_valid("ovr_frame_start", 64);
    repeat (40) step();
    check("overruns_after_40", {24'd0, overruns}, 32'd2);
    sif.ready = 1'b1;
    wait_done("ovr_frame_done", 64);
    // One more tick lands on the 8th handshake edge while still sending.
    check("overruns_after_drain", {24'd0, overruns}, 32'd3);

    sif.ready = 1'b0;
    push_frame(16'hFEDC, 16'hBA98, 16'h7654);
    wait_valid("sat_frame_start", 64);
    repeat (Period * 260) step();
    check("overruns_saturated", {24'd0, overruns}, 32'd255);
    sif.ready = 1'b1;
    wait_done("sat_frame_done", 64);
    check("overruns_still_sat", {24'd0, overruns}, 32'd255);

    // Test 3: ready 1-0-0-1 stalls; inputs change after the snapshot.
    push_frame(16'h8001, 16'h00FF, 16'hC3C3);
    wait_valid("stall_frame_start", 64);
    x = 16'h7777;
    y = 16'h0000;
    z = 16'h5555;
    pat = 4'b1001;
    for (int i = 0; i < 200; i++) begin
      sif.ready = pat[i % 4];
      step();
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
    check("stall_frame_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: reset while byte 4 is presented.
    sif.ready = 1'b1;
    push_frame(16'h0F0F, 16'hF0F0, 16'h1111);
    for (int i = 0; i < 64; i++) begin
      step();
      if (exp_q.size() == 5) break;
    end
    check("abort_reached_byte4", 32'(exp_q.size()), 32'd5);
    mon_en    = 1'b0;
    sif.ready = 1'b0;
    reset     = 1'b1;
    step();
    step();
    check("abort_valid", {31'd0, sif.valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overruns", {24'd0, overruns}, 32'd0);
    check("abort_data", {24'd0, sif.data}, 32'd0);
    exp_q.delete();
    exp_seq   = 8'd0;
    reset     = 1'b0;
    sif.ready = 1'b1;
    step();
    mon_en = 1'b1;
    push_frame(16'h2468, 16'h1357, 16'h9ABC);
    wait_done("post_reset_frame_done", 64);
    check("post_reset_overruns", {24'd0, overruns}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
